iir_sos_cascade: RTL

Parametrised cascade of NSEC Direct-Form-I biquad sections that share one time-multiplexed multiply-accumulate unit. It is the next generation of the single-section biquad: configurable width, section count and coefficient memory, with ready/valid input, rounding and a sticky saturation flag. It sits in the filter datapath between the sample source and downstream decimation/output logic.

---
 rtl/iir_sos_cascade.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/iir_sos_cascade.sv
`default_nettype none
// ============================================================================
// Module   : iir_sos_cascade
// Function : Cascade of NSEC Direct-Form-I biquads sharing one time-multiplexed
//            multiply-accumulate unit. Ready/valid input, coefficient memory,
//            clamped outputs and a sticky saturation flag.
// Option   : define IIR_ROUND_EN for round-half-up at write-back; otherwise
//            the write-back shift truncates toward minus infinity.
// Revision : 1.0  initial release
// ============================================================================
module iir_sos_cascade #(
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int FRAC  = 14,
  parameter int NSEC  = 4,
  parameter int GUARD = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DW-1:0]               in_data,
  input  logic                        coef_we,
  input  logic [$clog2(NSEC*5)-1:0]   coef_addr,
  input  logic [CW-1:0]               coef_wdata,
  input  logic                        clr_state,
  output logic                        out_valid,
  output logic [DW-1:0]               out_data,
  output logic                        sat_flag
);

  localparam int NCOEF = NSEC * 5;
  localparam int AW    = $clog2(NCOEF);
  localparam int SW    = (NSEC > 1) ? $clog2(NSEC) : 1;
  localparam int PW    = DW + CW;
  localparam int ACCW  = DW + CW + GUARD;

  localparam logic [CW-1:0] UNITY = CW'(1) << FRAC;
  localparam logic signed [ACCW:0] MAXV = {{(ACCW+2-DW){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW:0] MINV = {{(ACCW+2-DW){1'b1}}, {(DW-1){1'b0}}};
`ifdef IIR_ROUND_EN
  localparam logic signed [ACCW:0] RND = (ACCW+1)'(1) << (FRAC-1);
`else
  localparam logic signed [ACCW:0] RND = '0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t                 state;
  logic [SW-1:0]          sec;
  logic [2:0]             step;
  logic signed [CW-1:0]   coef [NCOEF];
  logic signed [DW-1:0]   x1 [NSEC];
  logic signed [DW-1:0]   x2 [NSEC];
  logic signed [DW-1:0]   y1 [NSEC];
  logic signed [DW-1:0]   y2 [NSEC];
  logic signed [DW-1:0]   cur_x;
  logic signed [ACCW-1:0] acc;

  logic [AW-1:0]          coef_idx;
  logic signed [CW-1:0]   coef_sel;
  logic signed [DW-1:0]   operand;
  logic signed [PW-1:0]   product;
  logic signed [ACCW-1:0] term;
  logic signed [ACCW-1:0] base;
  logic signed [ACCW-1:0] acc_next;
  logic signed [ACCW:0]   acc_ext;
  logic signed [ACCW:0]   acc_rnd;
  logic signed [ACCW:0]   shifted;
  logic signed [DW-1:0]   wb_val;
  logic                   wb_sat;

  assign in_ready = (state == S_IDLE);

  // Select coefficient and history operand for the current MAC step (b0,b1,b2,a1,a2).
  always_comb begin
    coef_idx = AW'(int'(sec) * 5 + int'(step));
    coef_sel = coef[coef_idx];
    case (step)
      3'd1:    operand = x1[sec];
      3'd2:    operand = x2[sec];
      3'd3:    operand = y1[sec];
      3'd4:    operand = y2[sec];
      default: operand = cur_x;
    endcase
    product  = coef_sel * operand;
    term     = {{GUARD{product[PW-1]}}, product};
    base     = (step == 3'd0) ? '0 : acc;
    acc_next = (step >= 3'd3) ? (base - term) : (base + term);
  end

  // Write-back: optional rounding, arithmetic shift by FRAC, clamp to sample range.
  always_comb begin
    acc_ext = $signed({acc[ACCW-1], acc});
    acc_rnd = acc_ext + RND;
    shifted = acc_rnd >>> FRAC;
    wb_val  = shifted[DW-1:0];
    wb_sat  = 1'b0;
    if (shifted > MAXV) begin
      wb_val = MAXV[DW-1:0];
      wb_sat = 1'b1;
    end else if (shifted < MINV) begin
      wb_val = MINV[DW-1:0];
      wb_sat = 1'b1;
    end
  end

  // Coefficient memory: resets to passthrough, writable only while idle and in range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCOEF; k++) begin
        coef[k] <= (k % 5 == 0) ? UNITY : '0;
      end
    end else if (coef_we && (state == S_IDLE) && (int'(coef_addr) < NCOEF)) begin
      coef[coef_addr] <= coef_wdata;
    end
  end

  // Sequencer and datapath: accept, 5 MAC steps + 1 write-back per section, clear/abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      sec       <= '0;
      step      <= '0;
      acc       <= '0;
      cur_x     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      sat_flag  <= 1'b0;
      for (int k = 0; k < NSEC; k++) begin
        x1[k] <= '0;
        x2[k] <= '0;
        y1[k] <= '0;
        y2[k] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      if (clr_state) begin
        // Clear wins over accept and aborts any sample in flight.
        state    <= S_IDLE;
        sat_flag <= 1'b0;
        for (int k = 0; k < NSEC; k++) begin
          x1[k] <= '0;
          x2[k] <= '0;
          y1[k] <= '0;
          y2[k] <= '0;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (in_valid) begin
              cur_x <= in_data;
              sec   <= '0;
              step  <= '0;
              state <= S_MAC;
            end
          end
          S_MAC: begin
            acc <= acc_next;
            if (step == 3'd4) begin
              step  <= '0;
              state <= S_WB;
            end else begin
              step <= step + 3'd1;
            end
          end
          S_WB: begin
            x2[sec] <= x1[sec];
            x1[sec] <= cur_x;
            y2[sec] <= y1[sec];
            y1[sec] <= wb_val;
            cur_x   <= wb_val;
            if (wb_sat) begin
              sat_flag <= 1'b1;
            end
            if (sec == SW'(NSEC - 1)) begin
              out_valid <= 1'b1;
              out_data  <= wb_val;
              state     <= S_IDLE;
            end else begin
              sec   <= sec + 1'b1;
              state <= S_MAC;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
